debouncer: RTL and testbench
============================

# debouncer

Multi-bit debouncer with built-in two-flop synchronizer for raw board inputs (push-buttons, switches). It sits directly upstream of the rising-edge detector: raw pad signals enter here, and the stable, glitch-free level it produces feeds the edge detector, which turns each press into a one-cycle pulse. Each bit is filtered independently. All bits share one sample-rate timebase.

## Interface
- `WIDTH`, default 1: number of independent input bits.
- `SAMPLE_CNT_MAX`, default 25000: sample period in clock cycles; must be ≥1.
- `PULSE_CNT_MAX`, default 150: number of consecutive high samples required before the output asserts; must be ≥1.
- `clk`, input, 1: single clock; every flop is on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `signal_in`, input, WIDTH: raw, asynchronous, possibly bouncing inputs.
- `debounced_out`, output, WIDTH: debounced, synchronized level per bit.

## Operation
- **Synchronizer:** per bit, `sync1 <= signal_in`, then `sync2 <= sync1`. Only `sync2` is used downstream.
- **Sample timebase:** one shared counter `sample_cnt`.
  - Width is `$clog2(SAMPLE_CNT_MAX)`, minimum 1.
  - It counts 0 to `SAMPLE_CNT_MAX-1` and wraps to 0.
  - `tick` is combinational: `tick = (sample_cnt == SAMPLE_CNT_MAX-1)`.
  - With `SAMPLE_CNT_MAX=1`, `tick` is high every cycle.
- **Per-bit saturating counter:** `cnt[i]`, width `$clog2(PULSE_CNT_MAX+1)`. Update rules, highest priority first:
  - `sync2[i]==0`: `cnt[i] <= 0` on every cycle, regardless of `tick`.
  - `sync2[i]==1 && tick && cnt[i] < PULSE_CNT_MAX`: `cnt[i] <= cnt[i]+1`.
  - Otherwise: hold. At `PULSE_CNT_MAX` the counter saturates and never wraps.
- **Output:** `debounced_out[i] = (cnt[i] == PULSE_CNT_MAX)`. This is a compare on registered state, so there is no glitch path from `signal_in`.
- **Behaviour is asymmetric:**
  - Assertion requires `PULSE_CNT_MAX` consecutive high samples.
  - Deassertion happens on the first synchronized low, even one lasting a single cycle.
  - This is intended: a press is filtered, a release is immediate.
- **Bit independence:** bits never interact except through the shared `tick`.
- **Reset:** clears `sync1`, `sync2`, `sample_cnt` and all `cnt[i]` to 0.
  - `debounced_out` is 0 from the first edge with `rst` high.
  - Reset mid-count discards all progress. After release, the timebase restarts from 0.
- **Width rules:** all compares are unsigned. Parameter values that do not fit their counter widths are illegal, and the implementation must not silently truncate them.

## Timing
- Reset value of every output: `debounced_out = {WIDTH{1'b0}}`.
- **Synchronizer latency:** a change sampled at edge k appears on `sync2` after edge k+1.
- **First tick:** the first `tick` after reset release occurs in the `SAMPLE_CNT_MAX`-th cycle (`sample_cnt == SAMPLE_CNT_MAX-1`). Later ticks follow every `SAMPLE_CNT_MAX` cycles.
- **Assert latency:** for input held high from edge k, `debounced_out` rises after the edge on which the `PULSE_CNT_MAX`-th tick with `sync2` high is registered. Bounds:
  - Minimum: 2 + (`PULSE_CNT_MAX`-1)·`SAMPLE_CNT_MAX` + 1 cycles.
  - Maximum: 2 + `PULSE_CNT_MAX`·`SAMPLE_CNT_MAX` cycles.
  - The exact value depends on tick phase.
- **Deassert latency:** input low sampled at edge k gives `cnt` = 0 after edge k+2, so `debounced_out` is low in the cycle after edge k+2. This is exactly 3 cycles, independent of tick phase.
- **Simultaneous events:**
  - `rst` overrides everything.
  - A low `sync2` on a `tick` cycle clears `cnt`; it does not increment it.
- **Downstream:** the edge detector adds its own latency. This block guarantees `debounced_out` changes at most once per `SAMPLE_CNT_MAX` cycles while rising, so each clean press yields exactly one downstream pulse.

## Test plan
All scenarios use `WIDTH=2`, `SAMPLE_CNT_MAX=4`, `PULSE_CNT_MAX=3` unless noted.
1. **Clean press.** Stimulus: release reset, then drive `signal_in=2'b01` and hold it. Required: `debounced_out[0]` rises 11–14 cycles after the drive and stays 1 for 100 cycles with `cnt[0]` saturated at 3; `debounced_out[1]` stays 0 throughout.
2. **Bounce rejection.** Stimulus: toggle bit 0 high/low every 5 cycles for 200 cycles. Required: `debounced_out[0]` is 0 throughout. Then hold the input high: the output asserts within 14 cycles.
3. **Release and glitch.** Stimulus: with `debounced_out=2'b11`, drop bit 1 low for exactly 1 cycle. Required: `debounced_out[1]` falls exactly 3 cycles later and re-asserts only after 3 further high ticks; bit 0 is unaffected.
4. **Reset mid-operation.** Stimulus: assert `rst` for 1 cycle while `cnt[0]==2`, with the input still high. Required: output is 0 and all counters are 0 on the next edge; the output re-asserts 11–14 cycles after `rst` falls.
5. **Minimum parameters.** Stimulus: with `SAMPLE_CNT_MAX=1`, `PULSE_CNT_MAX=1`, drive input high. Required: `debounced_out` rises exactly 3 cycles later and falls exactly 3 cycles after the input drops.
6. **Chained to the edge detector.** Stimulus: run scenario 1 with the edge detector attached downstream. Required: exactly one single-cycle pulse per press; zero pulses during the bounce in scenario 2.

Source files
------------

// File: rtl/debouncer.sv
`default_nettype none
// ============================================================================
// Module  : debouncer
// Brief   : Per-bit two-flop synchronizer plus sampled saturating debounce
//           counter; press is filtered, release is immediate.
// Revision: 1.0 - initial release
// ============================================================================
module debouncer #(
  parameter int WIDTH          = 1,
  parameter int SAMPLE_CNT_MAX = 25000,
  parameter int PULSE_CNT_MAX  = 150
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] signal_in,
  output logic [WIDTH-1:0] debounced_out
);

  localparam int SW = (SAMPLE_CNT_MAX > 1) ? $clog2(SAMPLE_CNT_MAX) : 1;
  localparam int PW = $clog2(PULSE_CNT_MAX + 1);

  // Reject out-of-range parameters at elaboration instead of truncating them.
  generate
    if (WIDTH < 1 || SAMPLE_CNT_MAX < 1 || PULSE_CNT_MAX < 1) begin : g_bad_params
      $error("debouncer: WIDTH, SAMPLE_CNT_MAX and PULSE_CNT_MAX must all be >= 1");
    end
  endgenerate

  localparam logic [SW-1:0] c_sample_last = SW'(SAMPLE_CNT_MAX - 1);
  localparam logic [PW-1:0] c_pulse_max   = PW'(PULSE_CNT_MAX);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [SW-1:0]    r_sample_cnt;
  logic             w_tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= signal_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_tick = (r_sample_cnt == c_sample_last);

  always_ff @(posedge clk) begin
    if (rst || w_tick) begin
      r_sample_cnt <= '0;
    end else begin
      r_sample_cnt <= r_sample_cnt + 1'b1;
    end
  end

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic [PW-1:0] r_cnt;

      // A low synchronized level wins over a coincident tick.
      always_ff @(posedge clk) begin
        if (rst || !r_sync2[i]) begin
          r_cnt <= '0;
        end else if (w_tick && (r_cnt < c_pulse_max)) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign debounced_out[i] = (r_cnt == c_pulse_max);
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_debouncer.sv
`default_nettype none
// Bench for debouncer: two instances (4/3 and 1/1 timebase) checked each cycle
// against an arithmetic tick-counting model, plus directed latency checks.
module tb_debouncer;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] signal_in;
  logic [1:0] out_a;
  logic [1:0] out_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  debouncer #(.WIDTH(2), .SAMPLE_CNT_MAX(4), .PULSE_CNT_MAX(3)) u_dut_a (
    .clk(clk), .rst(rst), .signal_in(signal_in), .debounced_out(out_a)
  );

  debouncer #(.WIDTH(2), .SAMPLE_CNT_MAX(1), .PULSE_CNT_MAX(1)) u_dut_b (
    .clk(clk), .rst(rst), .signal_in(signal_in), .debounced_out(out_b)
  );

  // Model: p counts edges since reset; a bit is high once the number of tick
  // phases (p mod S == S-1) inside its current unbroken synchronized-high run reaches P.
  typedef struct {
    logic [1:0] s1;
    logic [1:0] s2;
    longint     p;
    logic [1:0] valid;
    longint     st0;
    longint     st1;
    logic [1:0] exp;
  } model_t;

  model_t ma = '{default: 0};
  model_t mb = '{default: 0};

  function automatic model_t mnext(model_t m, longint s, longint pm, logic r, logic [1:0] din);
    model_t n = m;
    if (r) begin
      n.s1 = '0; n.s2 = '0; n.p = 0; n.valid = '0; n.exp = '0;
      return n;
    end
    for (int b = 0; b < 2; b++) begin
      longint st = (b == 0) ? m.st0 : m.st1;
      if (m.s2[b] !== 1'b1) begin
        n.valid[b] = 1'b0;
      end else begin
        if (!m.valid[b]) st = m.p;
        n.valid[b] = 1'b1;
      end
      n.exp[b] = n.valid[b] && (((m.p + 1) / s - st / s) >= pm);
      if (b == 0) n.st0 = st; else n.st1 = st;
    end
    n.p  = m.p + 1;
    n.s2 = m.s1;
    n.s1 = din;
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    ma = mnext(ma, 4, 3, rst, signal_in);
    mb = mnext(mb, 1, 1, rst, signal_in);
    #1;
    check("model_a", {30'd0, out_a}, {30'd0, ma.exp});
    check("model_b", {30'd0, out_b}, {30'd0, mb.exp});
  endtask

  initial begin
    int lat_a, lat_b, hold, nrst;

    // Reset
    rst = 1'b1; signal_in = 2'b00;
    #1;
    repeat (3) step();
    check("reset_a", {30'd0, out_a}, 32'd0);
    check("reset_b", {30'd0, out_b}, 32'd0);
    rst = 1'b0;
    repeat (2) step();

    // Clean press on bit 0
    signal_in = 2'b01;
    lat_a = -1; lat_b = -1;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (lat_a < 0 && out_a[0]) lat_a = c;
      if (lat_b < 0 && out_b[0]) lat_b = c;
    end
    check("press_lat_a_in_11_14", {31'd0, (lat_a >= 11 && lat_a <= 14)}, 32'd1);
    check("press_lat_b", lat_b, 32'd3);
    for (int c = 0; c < 100; c++) begin
      step();
      if (c % 20 == 0) check("press_hold_a", {30'd0, out_a}, 32'd1);
    end

    // Bounce: 5-cycle half periods, first half high
    for (int c = 0; c < 200; c++) begin
      signal_in[0] = ((c / 5) % 2 == 0);
      step();
      if (c >= 8 && c % 10 == 0) check("bounce_a0_low", {31'd0, out_a[0]}, 32'd0);
    end
    signal_in[0] = 1'b1;
    lat_a = -1;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (lat_a < 0 && out_a[0]) lat_a = c;
    end
    check("bounce_hold_lat_le_14", {31'd0, (lat_a >= 1 && lat_a <= 14)}, 32'd1);

    // Release glitch on bit 1
    signal_in = 2'b11;
    repeat (20) step();
    check("both_high_a", {30'd0, out_a}, 32'd3);
    signal_in = 2'b01;
    step();
    signal_in = 2'b11;
    step();
    check("glitch_before_fall_a1", {31'd0, out_a[1]}, 32'd1);
    check("glitch_before_fall_b1", {31'd0, out_b[1]}, 32'd1);
    step();
    check("glitch_fall_a1", {31'd0, out_a[1]}, 32'd0);
    check("glitch_fall_b1", {31'd0, out_b[1]}, 32'd0);
    check("glitch_a0_unaffected", {31'd0, out_a[0]}, 32'd1);
    repeat (20) step();
    check("glitch_reassert_a", {30'd0, out_a}, 32'd3);

    // Reset mid-count on bit 0
    signal_in = 2'b00;
    repeat (4) step();
    signal_in = 2'b01;
    repeat (6 + $urandom_range(0, 3)) step();
    rst = 1'b1;
    step();
    check("midrst_a", {30'd0, out_a}, 32'd0);
    check("midrst_b", {30'd0, out_b}, 32'd0);
    rst = 1'b0;
    lat_a = -1;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (lat_a < 0 && out_a[0]) lat_a = c;
    end
    check("midrst_relat_in_11_14", {31'd0, (lat_a >= 11 && lat_a <= 14)}, 32'd1);

    // Randomized inputs with random hold lengths and rare resets
    nrst = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 37 == 0) hold = 0;
      if (hold == 0) begin
        signal_in = 2'($urandom);
        hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 40)) : int'($urandom_range(1, 6));
      end
      hold--;
      rst = ($urandom_range(0, 249) == 0);
      if (rst) nrst++;
      step();
    end
    rst = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
